fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Two-requester write-port arbiter for the `fifo` block. Sits between two independent producers (e.g. two `onoff_fsm`-debounced input sources) and the single FIFO write port. Grants round-robin, issues one-cycle `wr` pulses only when the FIFO is not full, and acknowledges each accepted word back to its owner.

## Interface

Parameters:
- `B`, 4: data width; must match the FIFO `B`.
- `CW`, 8: statistics counter width; used only with `FIFO_ARB_CNT_EN`.

Ports:
- `clk`, input, 1: single system clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high; overrides all other inputs.
- `req0`, input, 1: requester 0 has a word pending; level signal, held until acked.
- `data0`, input, B: requester 0 word; stable while `req0`=1.
- `ack0`, output, 1: one-cycle pulse; requester 0 word written this cycle.
- `req1`, `data1`, `ack1`: same as above, for requester 1.
- `fifo_full`, input, 1: FIFO `full` flag.
- `fifo_wr`, output, 1: FIFO `wr` strobe; one-cycle pulse.
- `fifo_wr_data`, output, B: FIFO `wr_data`.
- `last_grant`, output, 1: id of the most recently granted requester.
- `cnt0`, `cnt1`, output, CW: accepted-word counters; present only with `FIFO_ARB_CNT_EN`.

## Operation

- FSM with two states:
  - IDLE: arbitrate.
  - WRITE: outputs asserted for exactly one cycle, then return to IDLE unconditionally.
- IDLE → WRITE when `fifo_full`=0 and (`req0`|`req1`)=1. Otherwise stay in IDLE with all strobes low.
- Grant selection:
  - Only one requester active: grant it.
  - Both active: grant the requester named by the priority bit `prio`.
- On a grant to requester i:
  - `prio` ← ~i; `last_grant` ← i.
  - `fifo_wr_data` ← data_i; `fifo_wr` ← 1; `ack_i` ← 1.
  - All of these are registered, so they are high during WRITE.
- In WRITE, `fifo_wr` and `ack_i` are high and the other ack is low. `fifo_wr_data` holds its value after WRITE (no zeroing).
- `req*` and `fifo_full` are ignored in WRITE. This dead cycle lets the requester drop or refresh `req` and lets the FIFO update `full`. It also guarantees no double write of a level-held request.
- Requester rule: at the edge where it samples `ack_i`=1, it deasserts `req_i` or presents the next word with `req_i` held.
- `fifo_full`=1 in IDLE: no grant; `prio` is unchanged; requests wait indefinitely. Words are never dropped.
- Reset values: state IDLE, `fifo_wr`=0, `ack0`=`ack1`=0, `fifo_wr_data`=0, `prio`=0 (requester 0 first), `last_grant`=0, counters 0.
- Reset asserted during WRITE: the `fifo_wr` already registered completes at that edge. All outputs are 0 from the next cycle. The FIFO shares `reset`, so its contents are discarded anyway.

## Timing

- `req_i` sampled high in IDLE at edge k → `fifo_wr`=`ack_i`=1 in cycle k+1 → FIFO stores the word at edge k+1.
- Maximum throughput: one word per 2 cycles. Two continuous requesters alternate 0,1,0,1.
- Worst-case wait for a requester with the other also continuous: 4 cycles from first sampled request.
- `fifo_full` is sampled only in IDLE, one cycle after the previous write, so the FIFO is never over-written.

## Configuration

- `FIFO_ARB_CNT_EN` defined:
  - `cnt0`/`cnt1` ports exist.
  - Each is CW-bit and increments at the edge ending a WRITE cycle for its requester.
  - Counters wrap modulo 2^CW and reset to 0.
- `FIFO_ARB_CNT_EN` undefined: counter ports and registers are absent. All other behaviour is identical.

## Structure

- Package `fifo_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_WRITE`);
  - requester ids `REQ0`=1'b0, `REQ1`=1'b1.
- Sub-module `rr_pick2`: combinational (`req0`, `req1`, `prio`) → (`gnt_valid`, `gnt_id`). Reusable for a later read-side scheduler.
- FSM, output registers and counters live in `fifo_wr_arbiter`.

## Test plan

- **Single requester:** reset, then `req0`=1 with `data0`=4'hA. Expect `fifo_wr`=1 with `fifo_wr_data`=4'hA and `ack0`=1 for one cycle, one cycle after sampling; `last_grant`=0.
- **Contention:** `req0` and `req1` both held continuously with data 4'h1 and 4'h2. Expect FIFO order 1,2,1,2; `fifo_wr` high every second cycle; acks never overlap.
- **Full stall:** `fifo_full`=1 with `req1`=1. Expect no `fifo_wr` for 10 cycles. Drop `fifo_full`; expect `fifo_wr`=1 with `ack1` one cycle later.
- **Fill to capacity (W=4, B=4):** `req0` streams 0..19. Expect exactly 16 writes, then the stall. Words 0..15 read back in order.
- **Reset in WRITE:** assert `reset` during the `fifo_wr` cycle. Expect all outputs 0 the next cycle and requester 0 granted first after release.
- **FIFO_ARB_CNT_EN, CW=8:** 300 grants to requester 0. Expect `cnt0`=44 (wrapped) and `cnt1`=0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM states (ARB_IDLE arbitrates, ARB_WRITE is the
//                 single strobe cycle).
//   REQ0 / REQ1 : requester ids as carried on gnt_id / last_grant.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: request/ack handshakes of both producers plus the FIFO
// write port, bundled for the arbiter.
//   req0/data0/ack0 : requester 0 word handshake (ack is a one-cycle pulse)
//   req1/data1/ack1 : requester 1 word handshake
//   fifo_full       : FIFO full flag into the arbiter
//   fifo_wr         : FIFO write strobe out of the arbiter
//   fifo_wr_data    : FIFO write data out of the arbiter
//   last_grant      : id of the most recently granted requester
// Modports: slave = arbiter side, master = producers/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int B = 4
);
  logic         req0;
  logic [B-1:0] data0;
  logic         ack0;
  logic         req1;
  logic [B-1:0] data1;
  logic         ack1;
  logic         fifo_full;
  logic         fifo_wr;
  logic [B-1:0] fifo_wr_data;
  logic         last_grant;

  modport slave (
    input  req0, data0, req1, data1, fifo_full,
    output ack0, ack1, fifo_wr, fifo_wr_data, last_grant
  );

  modport master (
    output req0, data0, req1, data1, fifo_full,
    input  ack0, ack1, fifo_wr, fifo_wr_data, last_grant
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick.
//   req0, req1 : request levels
//   prio       : requester preferred when both request
//   gnt_valid  : at least one request present
//   gnt_id     : chosen requester (REQ0 when none request)
module rr_pick2
  import fifo_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      gnt_id = prio;
    end else if (req1) begin
      gnt_id = REQ1;
    end else begin
      gnt_id = REQ0;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter of two producers onto one FIFO write
// port. A grant in IDLE registers fifo_wr/ack/data for exactly one WRITE
// cycle; the FSM then returns to IDLE, so a level-held request is never
// written twice and fifo_full is re-sampled only after the FIFO has updated.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fifo_wr_arbiter_if.slave (handshakes + FIFO write port)
//   cnt0, cnt1 : per-requester accepted-word counters (wrap mod 2^CW),
//                present only when FIFO_ARB_CNT_EN is defined
// Parameters: B data width (must match the interface), CW counter width.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int B  = 4,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_wr_arbiter_if.slave     bus
`ifdef FIFO_ARB_CNT_EN
  ,
  output logic [CW-1:0]        cnt0,
  output logic [CW-1:0]        cnt1
`endif
);

  if (B < 1 || CW < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: B and CW must be at least 1");
  end

  arb_state_e   state, state_nx;
  logic         prio, prio_nx;
  logic         wr_q, wr_nx;
  logic         ack0_q, ack0_nx;
  logic         ack1_q, ack1_nx;
  logic         lg_q, lg_nx;
  logic [B-1:0] data_q, data_nx;
  logic         gnt_valid, gnt_id;

  rr_pick2 u_pick (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .prio      (prio),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_nx = state;
    prio_nx  = prio;
    wr_nx    = 1'b0;
    ack0_nx  = 1'b0;
    ack1_nx  = 1'b0;
    lg_nx    = lg_q;
    data_nx  = data_q;
    case (state)
      ARB_IDLE: begin
        if (!bus.fifo_full && gnt_valid) begin
          state_nx = ARB_WRITE;
          prio_nx  = ~gnt_id;
          lg_nx    = gnt_id;
          wr_nx    = 1'b1;
          ack0_nx  = (gnt_id == REQ0);
          ack1_nx  = (gnt_id == REQ1);
          data_nx  = (gnt_id == REQ1) ? bus.data1 : bus.data0;
        end
      end
      ARB_WRITE: state_nx = ARB_IDLE;
      default:   state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARB_IDLE;
      prio   <= REQ0;
      wr_q   <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      lg_q   <= REQ0;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      prio   <= prio_nx;
      wr_q   <= wr_nx;
      ack0_q <= ack0_nx;
      ack1_q <= ack1_nx;
      lg_q   <= lg_nx;
      data_q <= data_nx;
    end
  end

  assign bus.fifo_wr      = wr_q;
  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.last_grant   = lg_q;
  assign bus.fifo_wr_data = data_q;

`ifdef FIFO_ARB_CNT_EN
  // Count at the edge that ends the WRITE cycle, i.e. when the FIFO stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (state == ARB_WRITE) begin
      if (ack0_q) cnt0 <= cnt0 + CW'(1);
      if (ack1_q) cnt1 <= cnt1 + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized scoreboard bench for fifo_wr_arbiter.
// A timestamp-based reference model predicts every write when a request is
// sampled; a negedge monitor compares the DUT outputs against the queue.
module tb_fifo_wr_arbiter;

  logic clk;
  logic reset;

  fifo_wr_arbiter_if #(.B(4)) bus ();

`ifdef FIFO_ARB_CNT_EN
  logic [7:0] cnt0, cnt1;
`endif

  fifo_wr_arbiter #(.B(4), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FIFO_ARB_CNT_EN
    ,
    .cnt0  (cnt0),
    .cnt1  (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       id;
    logic [3:0] data;
  } exp_t;

  exp_t q[$];

  int   checks = 0;
  int   errors = 0;
  int   e = 0;          // posedge count seen by the driver
  int   n = 0;          // negedge count seen by the monitor
  int   nwr = 0;        // DUT writes observed
  int   rst_edge = -1;  // last posedge at which reset was sampled

  // reference model state
  logic m_prio = 1'b0;
  int   m_free = 0;     // first edge at which a new grant may be issued
  int   m_cnt0 = 0;
  int   m_cnt1 = 0;
  logic g_hit;
  logic g_id;

  // requester behaviour
  int   ack_edge[2] = '{-1, -1};
  int   pol = 0;        // 0 drop, 1 hold same word, 2 random, 3 stream on req0
  int   seq = 0;
  logic cap_en = 1'b0;
  int   fill = 0;
  logic rnd_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // One clock edge: the model decides what the arbiter must do with the
  // inputs sampled at this edge.
  task automatic step();
    exp_t x;
    @(posedge clk);
    e++;
    g_hit = 1'b0;
    if (reset) begin
      rst_edge = e;
      m_prio = 1'b0;
      m_free = e + 1;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else if (e >= m_free && !bus.fifo_full && (bus.req0 || bus.req1)) begin
      g_id  = (bus.req0 && bus.req1) ? m_prio : bus.req1;
      g_hit = 1'b1;
      x.cyc  = e;
      x.id   = g_id;
      x.data = g_id ? bus.data1 : bus.data0;
      q.push_back(x);
      m_free = e + 2;
      m_prio = ~g_id;
      if (g_id) m_cnt1 = (m_cnt1 + 1) % 256;
      else      m_cnt0 = (m_cnt0 + 1) % 256;
    end
    #1;
  endtask

  task automatic requester_done(input int i);
    logic drop;
    drop = 1'b0;
    case (pol)
      0: drop = 1'b1;
      1: drop = 1'b0;
      2: begin
        drop = ($urandom_range(0, 1) == 0);
        if (!drop) begin
          if (i == 0) bus.data0 = 4'($urandom);
          else        bus.data1 = 4'($urandom);
        end
      end
      default: begin
        if (i == 0 && seq < 20) begin
          bus.data0 = 4'(seq);
          seq++;
        end else begin
          drop = 1'b1;
        end
      end
    endcase
    if (drop) begin
      if (i == 0) bus.req0 = 1'b0;
      else        bus.req1 = 1'b0;
    end
  endtask

  // Requesters react at the edge where they sample their ack.
  task automatic advance();
    step();
    if (g_hit) begin
      ack_edge[g_id] = e + 1;
      if (cap_en) fill++;
    end
    for (int i = 0; i < 2; i++) begin
      if (ack_edge[i] == e) begin
        ack_edge[i] = -1;
        requester_done(i);
      end
    end
    if (cap_en) bus.fifo_full = (fill >= 16);
    if (rnd_en) begin
      if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0  = 1'b1;
        bus.data0 = 4'($urandom);
      end
      if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1  = 1'b1;
        bus.data1 = 4'($urandom);
      end
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 99) == 0);
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) advance();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fifo_wr"},    bus.fifo_wr, 0);
    chk({tag, "_ack0"},       bus.ack0, 0);
    chk({tag, "_ack1"},       bus.ack1, 0);
    chk({tag, "_wr_data"},    bus.fifo_wr_data, 0);
    chk({tag, "_last_grant"}, bus.last_grant, 0);
  endtask

  // Monitor: every cycle the outputs must match the predicted write (if any),
  // and between writes data/last_grant hold their previous values.
  initial begin
    logic [3:0] hold;
    logic       lg;
    logic       act;
    exp_t       x;
    hold = '0;
    lg   = 1'b0;
    x.cyc = 0; x.id = 1'b0; x.data = '0;
    forever begin
      @(negedge clk);
      n++;
      if (rst_edge == n) begin
        hold = '0;
        lg   = 1'b0;
      end
      act = (q.size() > 0) && (q[0].cyc == n);
      if (act) begin
        x    = q.pop_front();
        hold = x.data;
        lg   = x.id;
      end
      if (bus.fifo_wr === 1'b1) nwr++;
      chk("fifo_wr",    bus.fifo_wr, act);
      chk("ack0",       bus.ack0, act && !x.id);
      chk("ack1",       bus.ack1, act && x.id);
      chk("wr_data",    bus.fifo_wr_data, hold);
      chk("last_grant", bus.last_grant, lg);
    end
  end

  initial begin
    int   w0;
    int   grants;
    logic got;

    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = '0;  bus.data1 = '0;
    bus.fifo_full = 1'b0;
    idle_cycles(2);
    chk_zero("reset");
    reset = 1'b0;
    idle_cycles(2);

    // single requester
    pol = 0;
    bus.req0 = 1'b1; bus.data0 = 4'hA;
    w0 = nwr;
    idle_cycles(6);
    chk("single_writes", nwr - w0, 1);

    // contention: both held continuously, alternate
    pol = 1;
    bus.req0 = 1'b1; bus.data0 = 4'h1;
    bus.req1 = 1'b1; bus.data1 = 4'h2;
    w0 = nwr;
    idle_cycles(16);
    chk("contention_writes", nwr - w0, 8);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    idle_cycles(3);

    // full stall
    pol = 0;
    bus.fifo_full = 1'b1;
    bus.req1 = 1'b1; bus.data1 = 4'h5;
    w0 = nwr;
    idle_cycles(10);
    chk("stall_writes", nwr - w0, 0);
    bus.fifo_full = 1'b0;
    idle_cycles(4);
    chk("stall_release_writes", nwr - w0, 1);

    // fill to capacity: stream 0..19 from requester 0, FIFO holds 16
    pol = 3; seq = 1; fill = 0; cap_en = 1'b1;
    bus.req0 = 1'b1; bus.data0 = 4'(0);
    w0 = nwr;
    idle_cycles(60);
    chk("fill_writes", nwr - w0, 16);
    cap_en = 1'b0;
    reset = 1'b1;
    advance();
    reset = 1'b0;
    bus.fifo_full = 1'b0;
    bus.req0 = 1'b0;
    idle_cycles(2);

    // reset during the WRITE cycle
    pol = 1;
    bus.req0 = 1'b1; bus.data0 = 4'h3;
    bus.req1 = 1'b1; bus.data1 = 4'hC;
    idle_cycles(3);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      advance();
      got = g_hit;
    end
    chk("grant_before_reset", got, 1);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    chk_zero("reset_in_write");
    advance();
    chk("first_after_reset_ack0", bus.ack0, 1);
    chk("first_after_reset_ack1", bus.ack1, 0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    idle_cycles(3);

    // 300 grants to requester 0 from a clean reset
    reset = 1'b1;
    advance();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.data0 = 4'h7;
    grants = 0;
    w0 = nwr;
    for (int i = 0; i < 700 && grants < 300; i++) begin
      advance();
      if (g_hit && g_id == 1'b0) grants++;
      if (grants == 300) bus.req0 = 1'b0;
    end
    idle_cycles(3);
    chk("burst_writes", nwr - w0, 300);
`ifdef FIFO_ARB_CNT_EN
    chk("cnt0_wrapped", cnt0, 44);
    chk("cnt1_idle", cnt1, 0);
`endif

    // random traffic with random full and occasional reset
    pol = 2;
    rnd_en = 1'b1;
    idle_cycles(3000);
    rnd_en = 1'b0;
    reset = 1'b0;
    bus.fifo_full = 1'b0;
    pol = 0;
    idle_cycles(12);
`ifdef FIFO_ARB_CNT_EN
    chk("cnt0_random", cnt0, m_cnt0);
    chk("cnt1_random", cnt1, m_cnt1);
`endif
    chk("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
